ysyx_23060187_imem: RTL and testbench

Instruction-memory responder for the ysyx_23060187 core: accepts a fetch request carrying the PC and returns the 32-bit instruction word after a configurable latency, using valid/ready handshakes on both request and response. It sits between the core's fetch stage and a word-addressed on-chip array. A side write port lets the loader or testbench preload the array. Misaligned and out-of-range fetches complete with an error flag and a defined trap instruction, so the core never stalls on a bad PC.

---
 rtl/ysyx_23060187_imem_pkg.sv | 29 ++
 rtl/ysyx_23060187_imem_if.sv | 33 +++
 rtl/ysyx_23060187_imem_sram.sv | 33 +++
 rtl/ysyx_23060187_imem.sv | 128 ++++++++++++
 tb/tb_ysyx_23060187_imem.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060187_imem_pkg.sv
// Shared types and constants for the ysyx_23060187 instruction memory.
// Also hosts the address check used by both the fetch path and the preload port.
package ysyx_23060187_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_e;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] RESET_PC    = 32'h8000_0000;

    // 33-bit compare so a window near the top of the address space cannot wrap past 2^32
    function automatic logic addr_valid(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'(depth) << 2);
        return (addr[1:0] == 2'b00) && (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/ysyx_23060187_imem_if.sv
// Fetch request/response channel between the core fetch stage and the instruction memory.
// Both directions use a valid/ready handshake.
interface ysyx_23060187_imem_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_inst,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_inst,
        output resp_err
    );

endinterface

// File: rtl/ysyx_23060187_imem_sram.sv
// DEPTH x 32 word array: synchronous write port, registered read port.
// A read and write to the same word in one cycle returns the old contents.
module ysyx_23060187_sram_1r1w #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [31:0]              wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [31:0]              rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Only the output register is cleared; the array survives reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 32'h0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/ysyx_23060187_imem.sv
// Instruction-memory responder: accepts a PC, returns the word after LATENCY cycles.
// Bad PCs complete with resp_err and an ebreak so the core never stalls on them.
module ysyx_23060187_imem
    import ysyx_23060187_pkg::*;
#(
    parameter logic [31:0] BASE    = RESET_PC,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_23060187_imem_if.slave        bus,
    input  logic                       wr_en,
    input  logic [31:0]                wr_addr,
    input  logic [31:0]                wr_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    imem_state_e   state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] idx;
    logic          err_q;
    logic          ready_q;
    logic          valid_q;

    logic          req_fire;
    logic          resp_fire;
    logic          req_bad;
    logic          wr_ok;
    logic [31:0]   req_off;
    logic [31:0]   wr_off;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] wr_idx;
    logic          rd_en;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_data;

    assign req_off   = bus.req_addr - BASE;
    assign wr_off    = wr_addr - BASE;
    assign req_idx   = AW'(req_off >> 2);
    assign wr_idx    = AW'(wr_off >> 2);
    assign req_bad   = !addr_valid(bus.req_addr, BASE, DEPTH);
    assign wr_ok     = wr_en && addr_valid(wr_addr, BASE, DEPTH);
    assign req_fire  = bus.req_valid && ready_q;
    assign resp_fire = valid_q && bus.resp_ready;

    // The array read is issued on the edge that enters RESP, and only for good addresses
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = idx;
        if (state == IDLE && req_fire && LATENCY == 1) begin
            rd_en  = !req_bad;
            rd_idx = req_idx;
        end else if (state == WAIT && cnt == CW'(1)) begin
            rd_en  = !err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        idx     <= req_idx;
                        err_q   <= req_bad;
                        ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state   <= RESP;
                            valid_q <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            state   <= WAIT;
                            cnt     <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state   <= RESP;
                        valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_fire) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    ysyx_23060187_sram_1r1w #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_err   = err_q;
    assign bus.resp_inst  = err_q ? INST_EBREAK : rd_data;

endmodule

// File: tb/tb_ysyx_23060187_imem.sv
// Scoreboard bench: three imem instances with LATENCY 1, 3 and 4 share one clock.
// Stimulus pushes expected responses; per-instance monitors pop and compare on handshakes.
module tb_ysyx_23060187_imem;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          rise;
    } exp_t;

    logic              clk = 1'b0;
    logic [2:0]        rst_v = 3'b111;
    logic [2:0]        req_valid_v = '0;
    logic [2:0][31:0]  req_addr_v = '0;
    logic [2:0]        resp_ready_v = 3'b111;
    logic [2:0]        wr_en_v = '0;
    logic [2:0][31:0]  wr_addr_v = '0;
    logic [2:0][31:0]  wr_data_v = '0;
    logic [2:0]        req_ready_v;
    logic [2:0]        resp_valid_v;
    logic [2:0]        resp_err_v;
    logic [2:0][31:0]  resp_inst_v;

    exp_t exp_q [3][$];
    int   cycle = 0;
    int   passed = 0;
    int   total = 0;
    int   busy = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    task automatic checkOutput(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL L%0d %s: got %h expected %h", latOf(k), name, act, exp);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 3 : 4;

        ysyx_23060187_imem_if bus ();

        ysyx_23060187_imem #(
            .BASE    (32'h8000_0000),
            .DEPTH   (1024),
            .LATENCY (L)
        ) dut (
            .clk     (clk),
            .rst     (rst_v[g]),
            .bus     (bus.slave),
            .wr_en   (wr_en_v[g]),
            .wr_addr (wr_addr_v[g]),
            .wr_data (wr_data_v[g])
        );

        assign bus.req_valid   = req_valid_v[g];
        assign bus.req_addr    = req_addr_v[g];
        assign bus.resp_ready  = resp_ready_v[g];
        assign req_ready_v[g]  = bus.req_ready;
        assign resp_valid_v[g] = bus.resp_valid;
        assign resp_err_v[g]   = bus.resp_err;
        assign resp_inst_v[g]  = bus.resp_inst;

        logic        prev_valid = 1'b0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_inst = '0;
        logic        prev_err = 1'b0;
        exp_t        e;

        always @(negedge clk) begin
            if (rst_v[g]) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checkOutput(g, "hold_valid", 32'(resp_valid_v[g]), 32'd1);
                    checkOutput(g, "hold_inst", resp_inst_v[g], prev_inst);
                    checkOutput(g, "hold_err", 32'(resp_err_v[g]), 32'(prev_err));
                end
                if (resp_valid_v[g]) checkOutput(g, "req_ready_busy", 32'(req_ready_v[g]), 32'd0);
                if (resp_valid_v[g] && !prev_valid) begin
                    if (exp_q[g].size() == 0) checkOutput(g, "spurious_resp", 32'd1, 32'd0);
                    else checkOutput(g, "rise_cycle", 32'(cycle), 32'(exp_q[g][0].rise));
                end
                if (resp_valid_v[g] && resp_ready_v[g]) begin
                    if (exp_q[g].size() == 0) begin
                        checkOutput(g, "extra_resp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q[g].pop_front();
                        checkOutput(g, "resp_inst", resp_inst_v[g], e.inst);
                        checkOutput(g, "resp_err", 32'(resp_err_v[g]), 32'(e.err));
                    end
                end
                prev_valid = resp_valid_v[g];
                prev_stall = resp_valid_v[g] && !resp_ready_v[g];
                prev_inst  = resp_inst_v[g];
                prev_err   = resp_err_v[g];
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] ei, input logic ee);
        int n = 0;
        req_addr_v[k]  = a;
        req_valid_v[k] = 1'b1;
        while (!req_ready_v[k] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready_v[k]) checkOutput(k, "req_ready_timeout", 32'd0, 32'd1);
        else exp_q[k].push_back('{inst: ei, err: ee, rise: cycle + latOf(k)});
        @(posedge clk); #1;
        req_valid_v[k] = 1'b0;
        wr_en_v[k]     = 1'b0;
    endtask

    task automatic waitIdle(input int k);
        int n = 0;
        while (!req_ready_v[k] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 3; k++) begin
            wr_addr_v[k] = a;
            wr_data_v[k] = d;
        end
        wr_en_v = 3'b111;
        @(posedge clk); #1;
        wr_en_v = 3'b000;
    endtask

    task automatic checkReset(input int k);
        checkOutput(k, "rst_req_ready", 32'(req_ready_v[k]), 32'd1);
        checkOutput(k, "rst_resp_valid", 32'(resp_valid_v[k]), 32'd0);
        checkOutput(k, "rst_resp_err", 32'(resp_err_v[k]), 32'd0);
        checkOutput(k, "rst_resp_inst", resp_inst_v[k], 32'h0);
    endtask

    logic [31:0] rnd_addr [7] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0800, 32'h8000_0FFC,
                                  32'h8000_1000, 32'h7FFF_FFFC, 32'h8000_0003};
    logic [31:0] rnd_inst [7] = '{32'h0010_0093, 32'h0020_0113, 32'h1234_5678, 32'hDEAD_BEEF,
                                  EBREAK, EBREAK, EBREAK};
    logic        rnd_err  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_v = 3'b000;
        @(negedge clk);
        for (int k = 0; k < 3; k++) checkReset(k);
        @(posedge clk); #1;

        preload(32'h8000_0000, 32'h0010_0093);
        preload(32'h8000_0004, 32'h0020_0113);
        preload(32'h8000_0008, 32'hAAAA_AAAA);
        preload(32'h8000_0800, 32'h1234_5678);
        preload(32'h8000_0FFC, 32'hDEAD_BEEF);
        preload(32'h8000_0006, 32'h0BAD_0001);
        preload(32'h8000_1000, 32'h0BAD_0002);

        $display("[TB] LATENCY=1 basic fetches and error cases");
        applyStimulus(0, 32'h8000_0000, 32'h0010_0093, 1'b0);
        applyStimulus(0, 32'h8000_0004, 32'h0020_0113, 1'b0);
        applyStimulus(0, 32'h8000_0002, EBREAK, 1'b1);
        applyStimulus(0, 32'h7FFF_FFFC, EBREAK, 1'b1);
        applyStimulus(0, 32'h8000_1000, EBREAK, 1'b1);
        applyStimulus(0, 32'hFFFF_FFFC, EBREAK, 1'b1);
        applyStimulus(0, 32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0);

        $display("[TB] read/write collision on word 2");
        waitIdle(0);
        wr_addr_v[0] = 32'h8000_0008;
        wr_data_v[0] = 32'h5555_5555;
        wr_en_v[0]   = 1'b1;
        applyStimulus(0, 32'h8000_0008, 32'hAAAA_AAAA, 1'b0);
        applyStimulus(0, 32'h8000_0008, 32'h5555_5555, 1'b0);

        $display("[TB] LATENCY=3 stalled response");
        resp_ready_v[1] = 1'b0;
        applyStimulus(1, 32'h8000_0000, 32'h0010_0093, 1'b0);
        repeat (8) @(posedge clk);
        #1 resp_ready_v[1] = 1'b1;

        $display("[TB] LATENCY=4 reset during WAIT");
        applyStimulus(2, 32'h8000_0004, 32'h0020_0113, 1'b0);
        @(posedge clk); #1;
        rst_v[2] = 1'b1;
        exp_q[2].delete();
        @(posedge clk); #1;
        rst_v[2] = 1'b0;
        @(negedge clk);
        checkReset(2);
        repeat (6) @(posedge clk);
        #1;
        applyStimulus(2, 32'h8000_0004, 32'h0020_0113, 1'b0);

        $display("[TB] random fetches with random resp_ready");
        waitIdle(0);
        waitIdle(1);
        busy = 2;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    int j = $urandom_range(0, 6);
                    applyStimulus(0, rnd_addr[j], rnd_inst[j], rnd_err[j]);
                end
                busy--;
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    int j = $urandom_range(0, 6);
                    applyStimulus(1, rnd_addr[j], rnd_inst[j], rnd_err[j]);
                end
                busy--;
            end
            begin
                while (busy != 0) begin
                    @(posedge clk); #1;
                    resp_ready_v[1:0] = 2'($urandom_range(0, 3));
                end
            end
        join
        resp_ready_v = 3'b111;

        for (int n = 0; n < 50; n++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) checkOutput(k, "missing_resp", 32'(exp_q[k].size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete, passed %0d of %0d", passed, total);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
